// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 load/store unit sitting between EX and WB.
// Ports: clk/resetn, EX valid/ready + fields, dmem req/rsp, wb retire, fwd_result
// Optional: MISALIGN_TRAP_EN adds misalign_trap and suppresses misaligned accesses.
module mem_access_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic [31:0] fwd_result
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [4:0]  h_rd;
  logic        h_rw;
  logic        h_we;
  logic [2:0]  h_f3;

  logic        is_mem;
  logic        sz_b;
  logic        sz_h;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        mis;
  logic [31:0] bsh;
  logic [31:0] hsh;
  logic [31:0] ld;

  assign ex_ready = (state == IDLE);
  assign is_mem   = ex_mem_read | ex_mem_write;

  // store sizes: only 000/001 are narrow; loads key on funct3[1:0]
  always_comb begin
    sz_b = 1'b0;
    sz_h = 1'b0;
    unique case (1'b1)
      ex_mem_write: begin
        sz_b = (ex_funct3 == 3'b000);
        sz_h = (ex_funct3 == 3'b001);
      end
      default: begin
        sz_b = (ex_funct3[1:0] == 2'b00);
        sz_h = (ex_funct3[1:0] == 2'b01);
      end
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = ex_store_data;
    unique case (1'b1)
      sz_b: begin
        be    = 4'b0001 << ex_alu_result[1:0];
        wdata = {4{ex_store_data[7:0]}};
      end
      sz_h: begin
        be    = 4'b0011 << {ex_alu_result[1], 1'b0};
        wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign mis = is_mem &
    ((sz_h & ex_alu_result[0]) |
     (~sz_b & ~sz_h & (|ex_alu_result[1:0])));
`else
  assign mis = 1'b0;
`endif

  // lane select from the held address
  assign bsh = dmem_rdata >> {fwd_result[1:0], 3'b000};
  assign hsh = dmem_rdata >> {fwd_result[1], 4'b0000};

  always_comb begin
    ld = dmem_rdata;
    unique case (1'b1)
      h_f3 == 3'b000: ld = {{24{bsh[7]}}, bsh[7:0]};
      h_f3 == 3'b100: ld = {24'd0, bsh[7:0]};
      h_f3 == 3'b001: ld = {{16{hsh[15]}}, hsh[15:0]};
      h_f3 == 3'b101: ld = {16'd0, hsh[15:0]};
      default:        ld = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      h_rd           <= '0;
      h_rw           <= 1'b0;
      h_we           <= 1'b0;
      h_f3           <= '0;
      fwd_result     <= '0;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= '0;
      dmem_we        <= 1'b0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
      wb_data        <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap  <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (ex_valid) begin
            h_rd       <= ex_rd;
            h_rw       <= ex_reg_write;
            h_we       <= ex_mem_write;
            h_f3       <= ex_funct3;
            fwd_result <= ex_alu_result;
            if (is_mem && !mis) begin
              state          <= REQ;
              dmem_req_valid <= 1'b1;
              dmem_addr      <= {ex_alu_result[31:2], 2'b00};
              dmem_we        <= ex_mem_write;
              dmem_be        <= be;
              dmem_wdata     <= wdata;
            end else begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write & ~mis;
              wb_data      <= ex_alu_result;
`ifdef MISALIGN_TRAP_EN
              misalign_trap <= mis;
`endif
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            if (h_we) begin
              state        <= IDLE;
              wb_valid     <= 1'b1;
              wb_rd        <= h_rd;
              wb_reg_write <= 1'b0;
              wb_data      <= fwd_result;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            state        <= IDLE;
            wb_valid     <= 1'b1;
            wb_rd        <= h_rd;
            wb_reg_write <= h_rw;
            wb_data      <= ld;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vector table plus hand sequences
// for stalls, delayed responses, reset in flight and misalignment.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [31:0] fwd_result;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk),
    .resetn(resetn),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr),
    .dmem_we(dmem_we),
    .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write),
    .wb_data(wb_data),
    .fwd_result(fwd_result)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_trap(misalign_trap)
`endif
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
  } vec_t;

  int total = 0;
  int bad = 0;
  vec_t v[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
    input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
    input logic [31:0] rdata, input logic [31:0] e_addr,
    input logic [3:0] e_be, input logic [31:0] e_wdata,
    input logic [31:0] e_wb);
    vec_t t;
    t.alu = alu; t.sd = sd; t.rd = rd; t.rw = rw;
    t.mr = mr; t.mw = mw; t.f3 = f3; t.rdata = rdata;
    t.e_addr = e_addr; t.e_be = e_be;
    t.e_wdata = e_wdata; t.e_wb = e_wb;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    ex_alu_result = t.alu;
    ex_store_data = t.sd;
    ex_rd = t.rd;
    ex_reg_write = t.rw;
    ex_mem_read = t.mr;
    ex_mem_write = t.mw;
    ex_funct3 = t.f3;
    ex_valid = 1'b1;
  endtask

  // issue a memory op and let it be accepted at once; ends at the
  // negedge after acceptance
  task automatic issue_accept(input vec_t t);
    @(negedge clk);
    drive(t);
    @(negedge clk);
    ex_valid = 1'b0;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
  endtask

  initial begin
    int n;
    vec_t t;
    v[0]  = mk(32'h1234, 0, 5, 1, 0, 0, 3'b000, 0, 0, 0, 0, 32'h1234);
    v[1]  = mk(32'h103, 32'hAB, 1, 0, 0, 1, 3'b000, 0,
               32'h100, 4'b1000, 32'hABABABAB, 0);
    v[2]  = mk(32'h102, 32'h1234CDEF, 2, 0, 0, 1, 3'b001, 0,
               32'h100, 4'b1100, 32'hCDEFCDEF, 0);
    v[3]  = mk(32'h204, 32'hDEADBEEF, 0, 0, 0, 1, 3'b010, 0,
               32'h204, 4'b1111, 32'hDEADBEEF, 0);
    v[4]  = mk(32'h8, 32'h11223344, 0, 0, 0, 1, 3'b100, 0,
               32'h8, 4'b1111, 32'h11223344, 0);
    v[5]  = mk(32'h2, 0, 3, 1, 1, 0, 3'b000, 32'h00800000,
               32'h0, 0, 0, 32'hFFFFFF80);
    v[6]  = mk(32'h2, 0, 4, 1, 1, 0, 3'b100, 32'h00800000,
               32'h0, 0, 0, 32'h00000080);
    v[7]  = mk(32'h2, 0, 6, 1, 1, 0, 3'b001, 32'h80010000,
               32'h0, 0, 0, 32'hFFFF8001);
    v[8]  = mk(32'h0, 0, 7, 1, 1, 0, 3'b101, 32'h1234F00D,
               32'h0, 0, 0, 32'h0000F00D);
    v[9]  = mk(32'h10, 0, 8, 1, 1, 0, 3'b010, 32'hCAFEBABE,
               32'h10, 0, 0, 32'hCAFEBABE);
    v[10] = mk(32'h14, 0, 9, 1, 1, 0, 3'b110, 32'h87654321,
               32'h14, 0, 0, 32'h87654321);
    v[11] = mk(32'h20, 32'h55, 10, 1, 1, 1, 3'b010, 0,
               32'h20, 4'b1111, 32'h00000055, 0);
    v[12] = mk(32'h3, 0, 11, 1, 1, 0, 3'b000, 32'h7F000000,
               32'h0, 0, 0, 32'h0000007F);
    v[13] = mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 3'b000, 0,
               0, 0, 0, 32'hFFFFFFFF);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 1);
    chk("rst_req_valid", 32'(dmem_req_valid), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_fwd", fwd_result, 0);
    chk("rst_addr", dmem_addr, 0);
    resetn = 1'b1;

    // vector table
    for (int i = 0; i < 14; i++) begin
      t = v[i];
      @(negedge clk);
      drive(t);
      chk($sformatf("v%0d_ready", i), 32'(ex_ready), 1);
      @(negedge clk);
      ex_valid = 1'b0;
      chk($sformatf("v%0d_fwd", i), fwd_result, t.alu);
      if (!t.mr && !t.mw) begin
        chk($sformatf("v%0d_wbv", i), 32'(wb_valid), 1);
        chk($sformatf("v%0d_wbd", i), wb_data, t.e_wb);
        chk($sformatf("v%0d_wbrd", i), 32'(wb_rd), 32'(t.rd));
        chk($sformatf("v%0d_wbrw", i), 32'(wb_reg_write), 32'(t.rw));
      end else begin
        chk($sformatf("v%0d_reqv", i), 32'(dmem_req_valid), 1);
        chk($sformatf("v%0d_addr", i), dmem_addr, t.e_addr);
        chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(t.mw));
        chk($sformatf("v%0d_wbv0", i), 32'(wb_valid), 0);
        if (t.mw) begin
          chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(t.e_be));
          chk($sformatf("v%0d_wdata", i), dmem_wdata, t.e_wdata);
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        chk($sformatf("v%0d_reqv0", i), 32'(dmem_req_valid), 0);
        if (t.mw) begin
          chk($sformatf("v%0d_st_wbv", i), 32'(wb_valid), 1);
          chk($sformatf("v%0d_st_wbrw", i), 32'(wb_reg_write), 0);
        end else begin
          chk($sformatf("v%0d_ld_wait", i), 32'(wb_valid), 0);
          dmem_rsp_valid = 1'b1;
          dmem_rdata = t.rdata;
          @(negedge clk);
          dmem_rsp_valid = 1'b0;
          chk($sformatf("v%0d_ld_wbv", i), 32'(wb_valid), 1);
          chk($sformatf("v%0d_ld_wbd", i), wb_data, t.e_wb);
          chk($sformatf("v%0d_ld_rd", i), 32'(wb_rd), 32'(t.rd));
          chk($sformatf("v%0d_ld_rw", i), 32'(wb_reg_write), 1);
        end
      end
    end

    // SB stalled by dmem_req_ready low for 3 cycles
    @(negedge clk);
    drive(v[1]);
    @(negedge clk);
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_reqv", 32'(dmem_req_valid), 1);
      chk("stall_addr", dmem_addr, 32'h100);
      chk("stall_be", 32'(dmem_be), 32'h8);
      chk("stall_wdata", dmem_wdata, 32'hABABABAB);
      chk("stall_ready", 32'(ex_ready), 0);
      @(negedge clk);
    end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("stall_wbv", 32'(wb_valid), 1);
    chk("stall_wbrw", 32'(wb_reg_write), 0);

    // LW with response delayed 4 cycles, then a stray response in IDLE
    issue_accept(v[9]);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid) n++;
      @(negedge clk);
    end
    chk("delay_early_wb", n, 0);
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("delay_wbv", 32'(wb_valid), 1);
    chk("delay_wbd", wb_data, 32'h0BADF00D);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_valid) n++;
    end
    chk("delay_extra_wb", n, 0);
    dmem_rsp_valid = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("stray_wbv", 32'(wb_valid), 0);
    chk("stray_ready", 32'(ex_ready), 1);

    // back-to-back ALU ops
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      t = v[0];
      t.alu = 32'h100 + i;
      t.rd = 5'(12 + i);
      drive(t);
      chk("b2b_ready", 32'(ex_ready), 1);
      @(negedge clk);
      chk("b2b_wbv", 32'(wb_valid), 1);
      chk("b2b_wbd", wb_data, 32'h100 + i);
      chk("b2b_rd", 32'(wb_rd), 12 + i);
    end
    ex_valid = 1'b0;

    // reset while in WAIT, then a late response
    issue_accept(v[9]);
    chk("rw_ready_pre", 32'(ex_ready), 0);
    #2 resetn = 1'b0;
    #1;
    chk("rw_ready", 32'(ex_ready), 1);
    chk("rw_reqv", 32'(dmem_req_valid), 0);
    chk("rw_wbv", 32'(wb_valid), 0);
    chk("rw_fwd", fwd_result, 0);
    @(negedge clk);
    resetn = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("rw_late_wbv", 32'(wb_valid), 0);
    chk("rw_late_wbd", wb_data, 0);

    // reset while a request is pending in REQ
    @(negedge clk);
    drive(v[3]);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rr_reqv_pre", 32'(dmem_req_valid), 1);
    #2 resetn = 1'b0;
    #1;
    chk("rr_reqv", 32'(dmem_req_valid), 0);
    chk("rr_be", 32'(dmem_be), 0);
    chk("rr_ready", 32'(ex_ready), 1);
    @(negedge clk);
    resetn = 1'b1;

`ifdef MISALIGN_TRAP_EN
    // misaligned LW at 0x6 traps without a memory request
    @(negedge clk);
    t = v[9];
    t.alu = 32'h6;
    drive(t);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mis_reqv", 32'(dmem_req_valid), 0);
    chk("mis_trap", 32'(misalign_trap), 1);
    chk("mis_wbv", 32'(wb_valid), 1);
    chk("mis_wbrw", 32'(wb_reg_write), 0);
    chk("mis_ready", 32'(ex_ready), 1);
    @(negedge clk);
    chk("mis_trap_clr", 32'(misalign_trap), 0);
    chk("mis_reqv2", 32'(dmem_req_valid), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
